// File: rtl/vram_hdma_controller_if.sv
// Signal bundle for the VRAM HDMA engine: CPU register port, source bus,
// VRAM write port and engine status.
interface vram_hdma_controller_if #(
  parameter int DST_W = 13
);
  logic             cpu_en;
  logic             cgb;
  logic [2:0]       reg_select;
  logic             write;
  logic [7:0]       wdata;
  logic [7:0]       rdata;
  logic             ppu_enable;
  logic             hblank_start;
  logic [15:0]      bus_addr;
  logic [7:0]       bus_rdata;
  logic [DST_W-1:0] vram_addr;
  logic [7:0]       vram_wdata;
  logic             vram_write;
  logic             cpu_halt;
  logic             hdma_active;

  // master: the DMA engine, which owns the source bus and the VRAM port
  modport master (
    input  cpu_en, cgb, reg_select, write, wdata, ppu_enable, hblank_start, bus_rdata,
    output rdata, bus_addr, vram_addr, vram_wdata, vram_write, cpu_halt, hdma_active
  );

  modport slave (
    output cpu_en, cgb, reg_select, write, wdata, ppu_enable, hblank_start, bus_rdata,
    input  rdata, bus_addr, vram_addr, vram_wdata, vram_write, cpu_halt, hdma_active
  );
endinterface

// File: rtl/vram_hdma_controller.sv
// CGB VRAM DMA engine behind HDMA1-HDMA5: general-purpose (CPU halted) and
// HBlank-paced block copies from the system bus into VRAM.
//
// state     | meaning
// IDLE      | no transfer; HDMA5 reports completion or cancel status
// GDMA      | general-purpose copy, one byte per cpu_en tick, CPU halted
// HDMA_WAIT | HBlank mode between blocks, waiting for a pending HBlank
// HDMA_XFER | HBlank mode moving one block, CPU halted
module vram_hdma_controller #(
  parameter int BLOCK_BYTES = 16,
  parameter int LEN_W       = 7,
  parameter int DST_W       = 13
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vram_hdma_controller_if.master hif
);

  localparam int OFS_W = $clog2(BLOCK_BYTES);
  localparam int CNT_W = LEN_W + 1;
  localparam logic [OFS_W-1:0] BYTE_LAST = OFS_W'(BLOCK_BYTES - 1);
  localparam logic [15:0]      SRC_MASK  = ~16'(BLOCK_BYTES - 1);
  localparam logic [DST_W-1:0] DST_MASK  = ~DST_W'(BLOCK_BYTES - 1);
  localparam logic [DST_W-1:0] DST_LO    = DST_W'(8'hFF);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GDMA      = 2'd1,
    HDMA_WAIT = 2'd2,
    HDMA_XFER = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [15:0]      src_shadow, src_cnt;
  logic [DST_W-1:0] dst_shadow, dst_cnt;
  logic [CNT_W-1:0] blocks_left, blocks_m1;
  logic [OFS_W-1:0] byte_cnt;
  logic             pending, cancelled, cancel_req;

  logic tick, reg_wr, wr_hdma5, start, cancel_wait, cancel_xfer;
  logic in_xfer, byte_xfer, block_done, last_block, hblank_hit, pend_take;

  always_comb begin
    tick        = hif.cpu_en & hif.cgb;
    reg_wr      = tick & hif.write;
    wr_hdma5    = reg_wr & (hif.reg_select == 3'd4);
    start       = wr_hdma5 & (state == IDLE);
    cancel_wait = wr_hdma5 & ~hif.wdata[7] & (state == HDMA_WAIT);
    cancel_xfer = wr_hdma5 & ~hif.wdata[7] & (state == HDMA_XFER);
    in_xfer     = (state == GDMA) | (state == HDMA_XFER);
    byte_xfer   = tick & in_xfer;
    block_done  = byte_xfer & (byte_cnt == '0);
    last_block  = (blocks_left == CNT_W'(1));
    hblank_hit  = hif.hblank_start & hif.ppu_enable & hif.cgb & (state == HDMA_WAIT);
    pend_take   = tick & pending & (state == HDMA_WAIT) & ~cancel_wait;
    blocks_m1   = blocks_left - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = hif.wdata[7] ? HDMA_WAIT : GDMA;
      end
      GDMA: begin
        if (block_done && last_block) state_nxt = IDLE;
      end
      HDMA_WAIT: begin
        if (cancel_wait)    state_nxt = IDLE;
        else if (pend_take) state_nxt = HDMA_XFER;
      end
      HDMA_XFER: begin
        // a cancel written mid-block only lands once the block is complete
        if (block_done)
          state_nxt = (last_block || cancel_req || cancel_xfer) ? IDLE : HDMA_WAIT;
      end
      default: state_nxt = IDLE;
    endcase
    if (!hif.cgb) state_nxt = IDLE;
  end

  always_comb begin
    hif.hdma_active = (state != IDLE);
    hif.cpu_halt    = in_xfer;
    hif.vram_write  = byte_xfer;
    hif.bus_addr    = in_xfer ? src_cnt : 16'd0;
    hif.vram_addr   = in_xfer ? dst_cnt : '0;
  end

  assign hif.vram_wdata = hif.bus_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_shadow  <= '0;
      dst_shadow  <= '0;
      src_cnt     <= '0;
      dst_cnt     <= '0;
      blocks_left <= '0;
      byte_cnt    <= '0;
      pending     <= 1'b0;
      cancelled   <= 1'b0;
      cancel_req  <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (hif.reg_select)
          3'd0: src_shadow <= {hif.wdata, src_shadow[7:0]} & SRC_MASK;
          3'd1: src_shadow <= {src_shadow[15:8], hif.wdata} & SRC_MASK;
          3'd2: dst_shadow <= ((DST_W'(hif.wdata) << 8) | (dst_shadow & DST_LO)) & DST_MASK;
          3'd3: dst_shadow <= ((dst_shadow & ~DST_LO) | DST_W'(hif.wdata)) & DST_MASK;
          default: ;
        endcase
      end

      if (start) begin
        src_cnt     <= src_shadow;
        dst_cnt     <= dst_shadow;
        blocks_left <= CNT_W'(hif.wdata[LEN_W-1:0]) + CNT_W'(1);
        byte_cnt    <= BYTE_LAST;
        cancelled   <= 1'b0;
        cancel_req  <= 1'b0;
      end

      if (byte_xfer) begin
        src_cnt  <= src_cnt + 16'd1;
        dst_cnt  <= dst_cnt + DST_W'(1);
        byte_cnt <= (byte_cnt == '0) ? BYTE_LAST : byte_cnt - OFS_W'(1);
      end

      if (block_done) blocks_left <= blocks_m1;

      if (cancel_xfer) cancel_req <= 1'b1;
      if (block_done && state == HDMA_XFER && !last_block && (cancel_req || cancel_xfer))
        cancelled <= 1'b1;
      if (cancel_wait) cancelled <= 1'b1;

      // with the LCD off no HBlank will ever come, so an HBlank start queues its first block
      if (start)
        pending <= hif.wdata[7] & ~hif.ppu_enable;
      else if (pend_take || cancel_wait || !hif.cgb)
        pending <= 1'b0;
      else if (hblank_hit)
        pending <= 1'b1;
    end
  end

  always_comb begin
    hif.rdata = 8'hFF;
    if (hif.cgb && hif.reg_select == 3'd4) begin
      if (state != IDLE) hif.rdata = {1'b0, 7'(blocks_m1[LEN_W-1:0])};
      else if (cancelled) hif.rdata = {1'b1, 7'(blocks_m1[LEN_W-1:0])};
    end
  end

endmodule

// File: tb/tb_vram_hdma_controller.sv
// Directed bench for vram_hdma_controller: a queue of expected byte copies
// (source, destination, data) is checked against every VRAM write.
module tb_vram_hdma_controller;
  localparam int BB    = 16;
  localparam int DST_W = 13;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vram_hdma_controller_if #(.DST_W(DST_W)) hif ();

  vram_hdma_controller #(.BLOCK_BYTES(BB), .LEN_W(7), .DST_W(DST_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hif     (hif)
  );

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  assign hif.bus_rdata = mem_byte(hif.bus_addr);

  typedef struct {
    logic [15:0]      src;
    logic [DST_W-1:0] dst;
  } xfer_t;

  xfer_t            exp_q[$];
  xfer_t            cur;
  int               n_cmp = 0;
  int               n_err = 0;
  int               wr_count = 0;
  int               halt_ticks = 0;
  logic [15:0]      last_baddr = '0;
  logic [DST_W-1:0] last_vaddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hif.cpu_halt === 1'b1 && hif.cpu_en === 1'b1) halt_ticks++;
    if (hif.vram_write === 1'b1) begin
      wr_count++;
      last_baddr = hif.bus_addr;
      last_vaddr = hif.vram_addr;
      check("write_on_tick", {31'd0, hif.cpu_en}, 32'd1);
      check("write_halted", {31'd0, hif.cpu_halt}, 32'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got vram_addr=%h bus_addr=%h, required no write",
                 hif.vram_addr, hif.bus_addr);
      end else begin
        cur = exp_q.pop_front();
        check("bus_addr", 32'(hif.bus_addr), 32'(cur.src));
        check("vram_addr", 32'(hif.vram_addr), 32'(cur.dst));
        check("vram_wdata", 32'(hif.vram_wdata), 32'(mem_byte(cur.src)));
      end
    end
  end

  task automatic push_copy(input int src, input int dst, input int n);
    xfer_t x;
    for (int i = 0; i < n; i++) begin
      x.src = 16'((src + i) % 65536);
      x.dst = DST_W'((dst + i) % (1 << DST_W));
      exp_q.push_back(x);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [2:0] sel, input logic [7:0] d);
    hif.reg_select = sel;
    hif.wdata      = d;
    hif.write      = 1'b1;
    cyc();
    hif.write      = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [2:0] sel, input logic [7:0] exp);
    hif.reg_select = sel;
    #1;
    check(name, 32'(hif.rdata), 32'(exp));
  endtask

  task automatic pulse();
    hif.hblank_start = 1'b1;
    cyc();
    hif.hblank_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit toggle, output int cycles);
    cycles = 0;
    while (cycles < max_cyc && !(exp_q.size() == 0 && hif.cpu_halt == 1'b0)) begin
      if (toggle) hif.cpu_en = ~hif.cpu_en;
      cyc();
      cycles++;
    end
    hif.cpu_en = 1'b1;
    if (cycles >= max_cyc) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_timeout: got %0d bytes still queued after %0d cycles, required 0",
               exp_q.size(), cycles);
    end
  endtask

  int w0, h0, c;
  logic [7:0] exp5 [3];

  initial begin
    reset_n          = 1'b0;
    hif.cpu_en       = 1'b1;
    hif.cgb          = 1'b1;
    hif.reg_select   = 3'd0;
    hif.write        = 1'b0;
    hif.wdata        = 8'h00;
    hif.ppu_enable   = 1'b1;
    hif.hblank_start = 1'b0;
    repeat (3) cyc();

    check("rst_vram_write", {31'd0, hif.vram_write}, 32'd0);
    check("rst_cpu_halt", {31'd0, hif.cpu_halt}, 32'd0);
    check("rst_active", {31'd0, hif.hdma_active}, 32'd0);
    check("rst_bus_addr", 32'(hif.bus_addr), 32'h0);
    check("rst_vram_addr", 32'(hif.vram_addr), 32'h0);
    reset_n = 1'b1;
    cyc();
    for (int s = 0; s < 8; s++) check_reg("rst_read", 3'(s), 8'hFF);

    // GDMA: 2 blocks from C000 to 0800
    wr_reg(3'd0, 8'hC0); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h08); wr_reg(3'd3, 8'h00);
    push_copy(16'hC000, 16'h0800, 32);
    w0 = wr_count; h0 = halt_ticks;
    wr_reg(3'd4, 8'h01);
    check("gdma_halt_asserted", {31'd0, hif.cpu_halt}, 32'd1);
    wait_done(200, 1'b0, c);
    check("gdma_cycles", 32'(c), 32'd32);
    check("gdma_writes", 32'(wr_count - w0), 32'd32);
    check("gdma_halt_ticks", 32'(halt_ticks - h0), 32'd32);
    check("gdma_last_src", 32'(last_baddr), 32'hC01F);
    check("gdma_last_dst", 32'(last_vaddr), 32'h081F);
    check_reg("gdma_hdma5", 3'd4, 8'hFF);

    // HDMA: 3 blocks, low block bits and out-of-range dst bits are masked off
    wr_reg(3'd0, 8'hD1); wr_reg(3'd1, 8'h3F); wr_reg(3'd2, 8'hE5); wr_reg(3'd3, 8'h47);
    w0 = wr_count;
    wr_reg(3'd4, 8'h82);
    check("hdma_active", {31'd0, hif.hdma_active}, 32'd1);
    check("hdma_wait_no_halt", {31'd0, hif.cpu_halt}, 32'd0);
    check_reg("hdma5_start", 3'd4, 8'h02);
    repeat (10) cyc();
    check("hdma_idle_wait", 32'(wr_count - w0), 32'd0);
    exp5[0] = 8'h01; exp5[1] = 8'h00; exp5[2] = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      push_copy(16'hD130 + 16 * k, 16'h0540 + 16 * k, 16);
      pulse();
      if (k == 1) begin
        repeat (3) cyc();
        wr_reg(3'd0, 8'h77);
      end
      wait_done(60, 1'b0, c);
      check_reg("hdma5_between", 3'd4, exp5[k]);
      if (k == 0) begin
        check("hdma_first_src", 32'(last_baddr), 32'hD13F);
        check("hdma_first_dst", 32'(last_vaddr), 32'h054F);
      end
    end
    check("hdma_writes", 32'(wr_count - w0), 32'd48);
    check("hdma_done_active", {31'd0, hif.hdma_active}, 32'd0);

    // cancel in HDMA_WAIT after one of four blocks
    wr_reg(3'd0, 8'h40); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h10); wr_reg(3'd3, 8'h00);
    w0 = wr_count;
    wr_reg(3'd4, 8'h83);
    push_copy(16'h4000, 16'h1000, 16);
    pulse();
    wait_done(60, 1'b0, c);
    check_reg("cancel_before", 3'd4, 8'h02);
    wr_reg(3'd4, 8'h00);
    check("cancel_idle", {31'd0, hif.hdma_active}, 32'd0);
    check_reg("cancel_hdma5", 3'd4, 8'h82);
    pulse();
    repeat (30) cyc();
    check("cancel_no_more", 32'(wr_count - w0), 32'd16);

    // repeated HBlank pulses: only one block per consumed pending flag
    wr_reg(3'd0, 8'h20); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h01); wr_reg(3'd3, 8'h00);
    w0 = wr_count;
    wr_reg(3'd4, 8'h81);
    push_copy(16'h2000, 16'h0100, 16);
    hif.cpu_en = 1'b0;
    pulse(); cyc(); pulse(); cyc();
    hif.cpu_en = 1'b1;
    repeat (4) cyc();
    pulse();
    wait_done(60, 1'b0, c);
    repeat (40) cyc();
    check("dbl_pulse_writes", 32'(wr_count - w0), 32'd16);
    check("dbl_pulse_active", {31'd0, hif.hdma_active}, 32'd1);
    check_reg("dbl_pulse_hdma5", 3'd4, 8'h00);
    wr_reg(3'd4, 8'h00);
    check_reg("dbl_cancel_hdma5", 3'd4, 8'h80);

    // GDMA with destination wrap and cpu_en at half rate
    wr_reg(3'd0, 8'h80); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h1F); wr_reg(3'd3, 8'hF0);
    push_copy(16'h8000, 16'h1FF0, 32);
    h0 = halt_ticks;
    wr_reg(3'd4, 8'h01);
    wait_done(200, 1'b1, c);
    check("wrap_cycles", 32'(c), 32'd64);
    check("wrap_halt_ticks", 32'(halt_ticks - h0), 32'd32);
    check("wrap_last_dst", 32'(last_vaddr), 32'h000F);
    check("wrap_last_src", 32'(last_baddr), 32'h801F);

    // HDMA start with LCD off: first block moves without an HBlank
    hif.ppu_enable = 1'b0;
    wr_reg(3'd0, 8'h12); wr_reg(3'd1, 8'h34); wr_reg(3'd2, 8'h03); wr_reg(3'd3, 8'h00);
    push_copy(16'h1230, 16'h0300, 16);
    w0 = wr_count;
    wr_reg(3'd4, 8'h80);
    wait_done(60, 1'b0, c);
    check("lcd_off_cycles", 32'(c), 32'd17);
    check("lcd_off_writes", 32'(wr_count - w0), 32'd16);
    check_reg("lcd_off_hdma5", 3'd4, 8'hFF);
    hif.ppu_enable = 1'b1;

    // reset after the fifth byte of a GDMA
    wr_reg(3'd0, 8'hA0); wr_reg(3'd1, 8'h00); wr_reg(3'd2, 8'h00); wr_reg(3'd3, 8'h00);
    push_copy(16'hA000, 16'h0000, 5);
    w0 = wr_count;
    wr_reg(3'd4, 8'h00);
    for (int i = 0; i < 20 && (wr_count - w0) < 5; i++) begin
      @(negedge clk);
      #1;
    end
    reset_n = 1'b0;
    cyc();
    check("rstmid_vram_write", {31'd0, hif.vram_write}, 32'd0);
    check("rstmid_cpu_halt", {31'd0, hif.cpu_halt}, 32'd0);
    check("rstmid_active", {31'd0, hif.hdma_active}, 32'd0);
    check("rstmid_bus_addr", 32'(hif.bus_addr), 32'h0);
    check_reg("rstmid_hdma5", 3'd4, 8'hFF);
    reset_n = 1'b1;
    cyc();
    check("rstmid_writes", 32'(wr_count - w0), 32'd5);
    push_copy(16'h0000, 16'h0000, 16);
    wr_reg(3'd4, 8'h00);
    wait_done(60, 1'b0, c);
    check_reg("rst_shadow_hdma5", 3'd4, 8'hFF);

    // DMG mode: block is inert
    hif.cgb = 1'b0;
    w0 = wr_count;
    wr_reg(3'd4, 8'h00);
    wr_reg(3'd4, 8'h80);
    check("dmg_active", {31'd0, hif.hdma_active}, 32'd0);
    repeat (20) cyc();
    check("dmg_writes", 32'(wr_count - w0), 32'd0);
    check_reg("dmg_hdma5", 3'd4, 8'hFF);
    hif.cgb = 1'b1;
    check_reg("dmg_back_hdma5", 3'd4, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vram_hdma_controller.md
Name: vram_hdma_controller

Overview:
- Parametrised CGB VRAM DMA engine behind HDMA1–HDMA5 (FF51–FF55); generalises the fixed-length OAM DMA path to variable-length, block-based copies into VRAM.
- Two modes:
  - General-purpose (GDMA): copies all blocks back to back while the CPU is halted.
  - HBlank (HDMA): copies one block per PPU HBlank, triggered by the PPU hblank_start pulse.
- Sits beside the PPU; drives the VRAM write port and the system bus read address while active.

Parameters:
- BLOCK_BYTES, 16, bytes per block; power of two ≥2.
- LEN_W, 7, width of the block-count field in HDMA5; max blocks = 2^LEN_W.
- DST_W, 13, VRAM byte address width; destination wraps modulo 2^DST_W.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cpu_en  in  1  CPU-rate enable; all register writes and byte transfers occur only on cycles with cpu_en=1
- cgb  in  1  1 = CGB mode; 0 = block inert
- reg_select  in  3  0..4 select HDMA1..HDMA5; 5..7 unmapped
- write  in  1  register write strobe, qualified by cpu_en
- wdata  in  8  register write data
- rdata  out  8  register read data (combinational)
- ppu_enable  in  1  LCDC.7
- hblank_start  in  1  one-clk pulse at HBlank entry of a visible line
- bus_addr  out  16  source address presented to the system bus
- bus_rdata  in  8  source byte, valid in the same cycle
- vram_addr  out  DST_W  VRAM destination address
- vram_wdata  out  8  equals bus_rdata
- vram_write  out  1  VRAM write strobe
- cpu_halt  out  1  stalls the CPU while a block is in transfer
- hdma_active  out  1  1 in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State IDLE; src/dst shadow registers and counters = 0; hblank pending flag = 0; cancelled flag = 0.
  - Outputs: vram_write, cpu_halt, hdma_active = 0; bus_addr = 0; vram_addr = 0.
  - HDMA5 reads 0xFF. Reset aborts any transfer immediately.
- Register writes:
  - HDMA1/2 set src[15:8] / src[7:0]. Low log2(BLOCK_BYTES) bits are forced to 0.
  - HDMA3/4 set dst high/low. Only bits [DST_W-1:0] are kept; low block bits are forced to 0.
  - Writes to shadow registers during a transfer do not alter the running counters.
- HDMA5 write in IDLE:
  - blocks = wdata[LEN_W-1:0] + 1. Working counters load from the shadow registers.
  - wdata[7]=0: go to GDMA.
  - wdata[7]=1: go to HDMA_WAIT. If ppu_enable=0 at this moment, one block is queued immediately (pending flag set).
- HDMA5 write with wdata[7]=0:
  - In HDMA_WAIT: cancel immediately; go to IDLE with cancelled=1.
  - In HDMA_XFER: cancel takes effect after the current block completes.
  - In GDMA: ignored.
- HDMA5 write with wdata[7]=1 while active: ignored.
- States:
  - IDLE.
  - GDMA: one byte per cpu_en tick; cpu_halt=1 throughout; go to IDLE after the last byte.
  - HDMA_WAIT: on a cpu_en tick with pending=1, clear pending and go to HDMA_XFER.
  - HDMA_XFER: BLOCK_BYTES bytes on consecutive cpu_en ticks; cpu_halt=1. Then decrement the block count; go to IDLE if it reaches 0 (or a cancel is pending), else to HDMA_WAIT.
- Byte transfer cycle (a cpu_en tick in a transfer state):
  - bus_addr = src; vram_addr = dst; vram_write = 1.
  - Then src+1 (wraps at 16 bits) and dst+1 (wraps modulo 2^DST_W).
- Timing:
  - cpu_halt asserts the clk after the starting write and deasserts the clk after the last byte.
  - GDMA of N blocks takes exactly N*BLOCK_BYTES cpu_en ticks.
- hblank_start handling:
  - Sets pending when in HDMA_WAIT and ppu_enable=1.
  - A pulse arriving in HDMA_XFER, or a second pulse before consumption, is dropped; at most one block is transferred per HBlank.
- HDMA5 read:
  - Active: {1'b0, remaining_blocks-1}.
  - IDLE after cancel: {1'b1, remaining_blocks-1}.
  - IDLE after completion or reset: 0xFF.
- Other reads: HDMA1–4 and unmapped selects read 0xFF.
- cgb=0: writes ignored, all reads 0xFF, state held IDLE.

Test Plan:
- GDMA: src=0xC000, dst=0x0800, HDMA5=0x01 → 32 vram_writes on consecutive cpu_en ticks covering dst 0x0800..0x081F from src 0xC000..0xC01F; cpu_halt high for exactly 32 ticks; HDMA5 then reads 0xFF.
- HDMA: HDMA5=0x82, ppu_enable=1, three hblank_start pulses → 16 writes after each pulse; reads 0x02, 0x01, 0x00 between blocks; 0xFF after the third block.
- Cancel: HDMA5=0x83, one block done, write HDMA5=0x00 in HDMA_WAIT → IDLE; reads 0x82; further hblank_start produces no writes.
- Wrap/edge: dst=0x1FF0, HDMA5=0x01 (GDMA) → dst wraps 0x1FFF→0x0000; two hblank_start pulses within one block → only one block moved; HDMA start with ppu_enable=0 → first block moves immediately.
- Reset mid-GDMA (reset_n=0 after byte 5) → vram_write and cpu_halt drop the next clk; HDMA5 reads 0xFF; cgb=0 → writes to HDMA5 produce no transfer.
